// File: rtl/enigma_rotor_stage_if.sv
// Bundles the wiring-config, position-control and symbol handshake signals of one rotor stage.
// The slave modport is the rotor's view; the master modport is the driver's view.
interface enigma_rotor_stage_if #(
    parameter int SW = 5
);
    logic          cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [SW-1:0] cfg_data;
    logic          cfg_ready;
    logic          table_ok;
    logic          pos_load;
    logic [SW-1:0] pos_val;
    logic          step;
    logic [SW-1:0] pos;
    logic          carry_out;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sym;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sym;
    logic          out_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, pos_load, pos_val, step,
               in_valid, in_sym, in_dir, out_ready,
        input  cfg_ready, table_ok, pos, carry_out, in_ready,
               out_valid, out_sym, out_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, pos_load, pos_val, step,
               in_valid, in_sym, in_dir, out_ready,
        output cfg_ready, table_ok, pos, carry_out, in_ready,
               out_valid, out_sym, out_err
    );
endinterface

// File: rtl/enigma_rotor_stage.sv
// Pipelined Enigma rotor stage: runtime-loadable wiring (forward + inverse tables),
// position stepping with notch carry, and a 2-stage valid/ready symbol datapath.
module enigma_rotor_stage #(
    parameter int ALPHA = 26,
    parameter int SW    = 5,
    parameter int NOTCH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    enigma_rotor_stage_if.slave   bus
);
    localparam int            DEPTH   = 1 << SW;
    localparam int            W1      = SW + 1;
    localparam logic [SW-1:0] ALPHA_S = SW'(ALPHA);
    localparam logic [SW-1:0] LAST_S  = SW'(ALPHA - 1);
    localparam logic [SW-1:0] NOTCH_S = SW'(NOTCH);
    localparam logic [SW-1:0] ONE_S   = SW'(1);
    localparam logic [W1-1:0] ALPHA_W = W1'(ALPHA);
    localparam logic [W1-1:0] ONE_W   = W1'(1);

    // True for a legal symbol 1..ALPHA.
    function automatic logic sym_ok(input logic [SW-1:0] s);
        return (s != {SW{1'b0}}) && (s <= ALPHA_S);
    endfunction

    // The wiring is a permutation when every inverse entry is set and both tables agree.
    function automatic logic perm_ok(input logic [SW-1:0] f [DEPTH],
                                     input logic [SW-1:0] v [DEPTH]);
        logic          ok;
        logic [SW-1:0] k;
        ok = 1'b1;
        for (int i = 1; i <= ALPHA; i++) begin
            k = SW'(i);
            if ((v[k] == {SW{1'b0}}) || (v[f[k]] != k) || (f[v[k]] != k)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    logic [SW-1:0] fwd_q [DEPTH];
    logic [SW-1:0] fwd_d [DEPTH];
    logic [SW-1:0] inv_q [DEPTH];
    logic [SW-1:0] inv_d [DEPTH];
    logic          table_ok_q, table_ok_d;
    logic [SW-1:0] pos_q, pos_d;
    logic          carry_q, carry_d;
    logic          s1_full_q, s1_full_d;
    logic          s1_dir_q, s1_dir_d;
    logic          s1_err_q, s1_err_d;
    logic [SW-1:0] s1_pos_q, s1_pos_d;
    logic [SW-1:0] s1_addr_q, s1_addr_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_sym_q, out_sym_d;
    logic          out_err_q, out_err_d;

    logic          s2_free_s, s1_adv_s, in_ready_s, accept_s;
    logic          cfg_ready_s, cfg_wr_s;
    logic [W1-1:0] sum_s, t_s;
    logic [SW-1:0] idx_s, w_s, red_s, res_s;
    logic          bad_s;

    // Handshake: S1 drains into the output register whenever that register is free.
    always_comb begin
        s2_free_s   = !out_valid_q || bus.out_ready;
        s1_adv_s    = s1_full_q && s2_free_s;
        in_ready_s  = !s1_full_q || s1_adv_s;
        accept_s    = bus.in_valid && in_ready_s;
        cfg_ready_s = !s1_full_q && !out_valid_q;
        cfg_wr_s    = bus.cfg_we && cfg_ready_s && sym_ok(bus.cfg_addr) && sym_ok(bus.cfg_data);
    end

    // Wiring tables; a write updates both directions at once.
    always_comb begin
        fwd_d = fwd_q;
        inv_d = inv_q;
        if (cfg_wr_s) begin
            fwd_d[bus.cfg_addr] = bus.cfg_data;
            inv_d[bus.cfg_data] = bus.cfg_addr;
        end else begin
            fwd_d = fwd_q;
        end
        table_ok_d = perm_ok(fwd_q, inv_q);
    end

    // Rotor position: load wins over step; carry only on a step off the notch.
    always_comb begin
        pos_d   = pos_q;
        carry_d = 1'b0;
        if (bus.pos_load) begin
            if (bus.pos_val <= LAST_S) begin
                pos_d = bus.pos_val;
            end else begin
                pos_d = pos_q;
            end
        end else if (bus.step) begin
            pos_d   = (pos_q == LAST_S) ? {SW{1'b0}} : pos_q + ONE_S;
            carry_d = (pos_q == NOTCH_S);
        end else begin
            pos_d = pos_q;
        end
    end

    // Stage 1: entry contact index (in_sym-1+pos) mod ALPHA, plus captured dir/pos/error.
    always_comb begin
        sum_s = {1'b0, bus.in_sym} + {1'b0, pos_q} - ONE_W;
        if (sum_s >= ALPHA_W) begin
            idx_s = SW'(sum_s - ALPHA_W);
        end else begin
            idx_s = SW'(sum_s);
        end
        s1_full_d = s1_full_q;
        s1_dir_d  = s1_dir_q;
        s1_err_d  = s1_err_q;
        s1_pos_d  = s1_pos_q;
        s1_addr_d = s1_addr_q;
        if (accept_s) begin
            s1_full_d = 1'b1;
            s1_dir_d  = bus.in_dir;
            s1_err_d  = !sym_ok(bus.in_sym) || !table_ok_q;
            s1_pos_d  = pos_q;
            s1_addr_d = idx_s + ONE_S;
        end else if (s1_adv_s) begin
            s1_full_d = 1'b0;
        end else begin
            s1_full_d = s1_full_q;
        end
    end

    // Stage 2: table lookup, then undo the rotor offset with a single conditional subtract.
    always_comb begin
        w_s   = s1_dir_q ? inv_q[s1_addr_q] : fwd_q[s1_addr_q];
        t_s   = {1'b0, w_s} + ALPHA_W - ONE_W - {1'b0, s1_pos_q};
        if (t_s >= ALPHA_W) begin
            red_s = SW'(t_s - ALPHA_W);
        end else begin
            red_s = SW'(t_s);
        end
        res_s = red_s + ONE_S;
        bad_s = s1_err_q || !sym_ok(w_s);
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_err_d   = out_err_q;
        if (s1_adv_s) begin
            out_valid_d = 1'b1;
            out_sym_d   = bad_s ? {SW{1'b0}} : res_s;
            out_err_d   = bad_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset (also flushes the pipeline).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_q[i] <= SW'(i);
                inv_q[i] <= SW'(i);
            end
            table_ok_q  <= 1'b1;
            pos_q       <= {SW{1'b0}};
            carry_q     <= 1'b0;
            s1_full_q   <= 1'b0;
            s1_dir_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_pos_q    <= {SW{1'b0}};
            s1_addr_q   <= ONE_S;
            out_valid_q <= 1'b0;
            out_sym_q   <= {SW{1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            fwd_q       <= fwd_d;
            inv_q       <= inv_d;
            table_ok_q  <= table_ok_d;
            pos_q       <= pos_d;
            carry_q     <= carry_d;
            s1_full_q   <= s1_full_d;
            s1_dir_q    <= s1_dir_d;
            s1_err_q    <= s1_err_d;
            s1_pos_q    <= s1_pos_d;
            s1_addr_q   <= s1_addr_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_s;
    assign bus.table_ok  = table_ok_q;
    assign bus.pos       = pos_q;
    assign bus.carry_out = carry_q;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_err   = out_err_q;
endmodule
